// File: rtl/latency_monitor.sv
// Per-lane packet latency monitor: timestamps sampled packet starts, pairs them with sampled
// completions through a FIFO and publishes windowed sum/count/max/min delay statistics.
module latency_monitor #(
    parameter int unsigned TS_WIDTH    = 32,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned SAMPLE_LOG2 = 2,
    parameter int unsigned SAMPLE_ID   = 1,
    parameter int unsigned WINDOW      = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    input  logic                 over_valid,
    output logic [TS_WIDTH-1:0]  count,
    output logic                 win_valid,
    output logic [ACC_WIDTH-1:0] win_delay_sum,
    output logic [31:0]          win_pkt_count,
    output logic [TS_WIDTH-1:0]  win_max_delay,
    output logic [TS_WIDTH-1:0]  win_min_delay,
    output logic                 win_ovf,
    output logic                 win_udf,
    output logic [DEPTH_LOG2:0]  fifo_level
);
    localparam int unsigned            Depth     = 2 ** DEPTH_LOG2;
    localparam logic [TS_WIDTH-1:0]    WinLast   = TS_WIDTH'(WINDOW);
    localparam logic [TS_WIDTH:0]      Period    = (TS_WIDTH+1)'(WINDOW) + (TS_WIDTH+1)'(1);
    localparam logic [SAMPLE_LOG2-1:0] SampleId  = SAMPLE_LOG2'(SAMPLE_ID);
    localparam logic [DEPTH_LOG2:0]    LevelFull = (DEPTH_LOG2+1)'(Depth);

    // Timer and sequence counters
    logic [TS_WIDTH-1:0]    count_q, count_d;
    logic [SAMPLE_LOG2-1:0] start_seq_q, start_seq_d, over_seq_q, over_seq_d;
    logic                   win_close, start_hit, over_hit;

    // Timestamp FIFO
    logic [TS_WIDTH-1:0]   mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  fifo_empty, fifo_full, push, pop, ovf_evt, udf_evt;

    // Delay pipeline
    logic                s1_valid_q, s2_valid_q;
    logic [TS_WIDTH-1:0] s1_start_q, s1_over_q, s2_delay_q, delay_d;

    // Window accumulators and snapshot
    logic [ACC_WIDTH-1:0] sum_q, sum_d, sum_acc, snap_sum_q, snap_sum_d;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [31:0]          pkt_q, pkt_d, pkt_acc, snap_pkt_q, snap_pkt_d;
    logic [TS_WIDTH-1:0]  max_q, max_d, max_acc, snap_max_q, snap_max_d;
    logic [TS_WIDTH-1:0]  min_q, min_d, min_acc, snap_min_q, snap_min_d;
    logic                 ovf_q, ovf_d, ovf_acc, snap_ovf_q, snap_ovf_d;
    logic                 udf_q, udf_d, udf_acc, snap_udf_q, snap_udf_d;

    assign win_close  = (count_q == WinLast);
    assign start_hit  = start_valid && (start_seq_q == SampleId);
    assign over_hit   = over_valid && (over_seq_q == SampleId);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LevelFull);
    // No push->pop bypass: an over seeing an empty FIFO underflows even if a start lands now.
    assign pop        = over_hit && !fifo_empty;
    assign push       = start_hit && (!fifo_full || pop);
    assign ovf_evt    = start_hit && fifo_full && !pop;
    assign udf_evt    = over_hit && fifo_empty;

    // Wrap-aware delay; valid while the true delay is shorter than one window period.
    always_comb begin
        if (s1_over_q >= s1_start_q) begin
            delay_d = TS_WIDTH'({1'b0, s1_over_q} - {1'b0, s1_start_q});
        end else begin
            delay_d = TS_WIDTH'({1'b0, s1_over_q} + Period - {1'b0, s1_start_q});
        end
    end

    always_comb begin
        count_d     = win_close ? '0 : count_q + TS_WIDTH'(1);
        start_seq_d = start_valid ? start_seq_q + SAMPLE_LOG2'(1) : start_seq_q;
        over_seq_d  = over_valid ? over_seq_q + SAMPLE_LOG2'(1) : over_seq_q;
        wr_ptr_d    = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        level_d     = level_q;
        if (push && !pop) begin
            level_d = level_q + (DEPTH_LOG2+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (DEPTH_LOG2+1)'(1);
        end
    end

    // Accumulator values including this cycle's commit and flag events
    always_comb begin
        sum_ext = {1'b0, sum_q} + (ACC_WIDTH+1)'(s2_delay_q);
        sum_acc = sum_q;
        pkt_acc = pkt_q;
        max_acc = max_q;
        min_acc = min_q;
        if (s2_valid_q) begin
            sum_acc = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
            pkt_acc = (pkt_q == '1) ? pkt_q : pkt_q + 32'd1;
            max_acc = (s2_delay_q > max_q) ? s2_delay_q : max_q;
            min_acc = (s2_delay_q < min_q) ? s2_delay_q : min_q;
        end
        ovf_acc = ovf_q | ovf_evt;
        udf_acc = udf_q | udf_evt;
    end

    always_comb begin
        sum_d      = sum_acc;
        pkt_d      = pkt_acc;
        max_d      = max_acc;
        min_d      = min_acc;
        ovf_d      = ovf_acc;
        udf_d      = udf_acc;
        snap_sum_d = snap_sum_q;
        snap_pkt_d = snap_pkt_q;
        snap_max_d = snap_max_q;
        snap_min_d = snap_min_q;
        snap_ovf_d = snap_ovf_q;
        snap_udf_d = snap_udf_q;
        if (win_close) begin
            snap_sum_d = sum_acc;
            snap_pkt_d = pkt_acc;
            snap_max_d = max_acc;
            snap_min_d = min_acc;
            snap_ovf_d = ovf_acc;
            snap_udf_d = udf_acc;
            sum_d      = '0;
            pkt_d      = '0;
            max_d      = '0;
            min_d      = '1;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            start_seq_q <= '0;
            over_seq_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_start_q  <= '0;
            s1_over_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_delay_q  <= '0;
            sum_q       <= '0;
            pkt_q       <= '0;
            max_q       <= '0;
            min_q       <= '1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            snap_sum_q  <= '0;
            snap_pkt_q  <= '0;
            snap_max_q  <= '0;
            snap_min_q  <= '1;
            snap_ovf_q  <= 1'b0;
            snap_udf_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            start_seq_q <= start_seq_d;
            over_seq_q  <= over_seq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            s1_valid_q  <= pop;
            s1_start_q  <= mem_q[rd_ptr_q];
            s1_over_q   <= count_q;
            s2_valid_q  <= s1_valid_q;
            s2_delay_q  <= delay_d;
            sum_q       <= sum_d;
            pkt_q       <= pkt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            snap_sum_q  <= snap_sum_d;
            snap_pkt_q  <= snap_pkt_d;
            snap_max_q  <= snap_max_d;
            snap_min_q  <= snap_min_d;
            snap_ovf_q  <= snap_ovf_d;
            snap_udf_q  <= snap_udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= count_q;
        end
    end

    // During the close cycle the snapshot is presented straight from the accumulators so that
    // win_valid and the data it qualifies coincide; afterwards the snapshot registers hold it.
    assign count         = count_q;
    assign fifo_level    = level_q;
    assign win_valid     = win_close;
    assign win_delay_sum = win_close ? sum_acc : snap_sum_q;
    assign win_pkt_count = win_close ? pkt_acc : snap_pkt_q;
    assign win_max_delay = win_close ? max_acc : snap_max_q;
    assign win_min_delay = win_close ? min_acc : snap_min_q;
    assign win_ovf       = win_close ? ovf_acc : snap_ovf_q;
    assign win_udf       = win_close ? udf_acc : snap_udf_q;

endmodule

// File: tb/tb_latency_monitor.sv
// Bench for latency_monitor: table-driven window scenarios, hand-written overflow/reset
// sequences and random traffic, all checked against a queue-based reference model.
module tb_latency_monitor;
    localparam int TS_WIDTH    = 32;
    localparam int ACC_WIDTH   = 40;
    localparam int DEPTH_LOG2  = 2;
    localparam int SAMPLE_LOG2 = 2;
    localparam int SAMPLE_ID   = 1;
    localparam int WINDOW      = 99;
    localparam int DEPTH       = 4;
    localparam int NSEQ        = 4;
    localparam int PERIOD      = WINDOW + 1;
    localparam longint unsigned MIN_INIT = 64'hFFFF_FFFF;
    localparam longint unsigned SUM_MAX  = 64'hFF_FFFF_FFFF;
    localparam longint unsigned PKT_MAX  = 64'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start_valid = 1'b0;
    logic                 over_valid = 1'b0;
    logic [TS_WIDTH-1:0]  count;
    logic                 win_valid;
    logic [ACC_WIDTH-1:0] win_delay_sum;
    logic [31:0]          win_pkt_count;
    logic [TS_WIDTH-1:0]  win_max_delay;
    logic [TS_WIDTH-1:0]  win_min_delay;
    logic                 win_ovf;
    logic                 win_udf;
    logic [DEPTH_LOG2:0]  fifo_level;

    latency_monitor #(
        .TS_WIDTH   (TS_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .SAMPLE_LOG2(SAMPLE_LOG2),
        .SAMPLE_ID  (SAMPLE_ID),
        .WINDOW     (WINDOW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .over_valid   (over_valid),
        .count        (count),
        .win_valid    (win_valid),
        .win_delay_sum(win_delay_sum),
        .win_pkt_count(win_pkt_count),
        .win_max_delay(win_max_delay),
        .win_min_delay(win_min_delay),
        .win_ovf      (win_ovf),
        .win_udf      (win_udf),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned sum;
        longint unsigned pkt;
        longint unsigned mx;
        longint unsigned mn;
        bit              ovf;
        bit              udf;
    } win_exp_t;

    // s_cnt: count of the sampled start in window 0 (0 = no starts); o_win/o_cnt: sampled over
    typedef struct {
        int       s_cnt;
        int       o_win;
        int       o_cnt;
        win_exp_t w0;
        win_exp_t w1;
    } vec_t;

    typedef struct {
        longint cyc;
        int     delay;
    } commit_t;

    int      n_cmp = 0;
    int      n_bad = 0;
    string   phase = "init";

    // Reference model state
    int              mcount, sseq, oseq;
    longint          cyc = 0;
    int              fifo_q[$];
    commit_t         pend_q[$];
    longint unsigned m_sum, m_pkt, m_max, m_min;
    bit              m_ovf, m_udf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0d expected %0d (t=%0t)", phase, name, act, exp, $time);
        end
    endtask

    task automatic acc_init();
        m_sum = 0; m_pkt = 0; m_max = 0; m_min = MIN_INIT; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_reset();
        mcount = 0; sseq = 0; oseq = 0;
        fifo_q.delete();
        pend_q.delete();
        acc_init();
    endtask

    // Called mid-cycle with the inputs applied this cycle.
    task automatic model_step(input bit s, input bit o);
        commit_t c;
        int      ts;
        chk("count", count, 64'(mcount));
        chk("fifo_level", fifo_level, 64'(fifo_q.size()));
        chk("win_valid", win_valid, 64'(mcount == WINDOW));
        if (o) begin
            if (oseq == SAMPLE_ID) begin
                if (fifo_q.size() == 0) begin
                    m_udf = 1'b1;
                end else begin
                    ts = fifo_q.pop_front();
                    c.cyc = cyc + 2;
                    c.delay = (mcount - ts + PERIOD) % PERIOD;
                    pend_q.push_back(c);
                end
            end
            oseq = (oseq + 1) % NSEQ;
        end
        if (s) begin
            if (sseq == SAMPLE_ID) begin
                if (fifo_q.size() < DEPTH) fifo_q.push_back(mcount);
                else m_ovf = 1'b1;
            end
            sseq = (sseq + 1) % NSEQ;
        end
        if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
            c = pend_q.pop_front();
            m_sum = (m_sum + 64'(c.delay) > SUM_MAX) ? SUM_MAX : m_sum + 64'(c.delay);
            m_pkt = (m_pkt == PKT_MAX) ? PKT_MAX : m_pkt + 1;
            if (64'(c.delay) > m_max) m_max = 64'(c.delay);
            if (64'(c.delay) < m_min) m_min = 64'(c.delay);
        end
        if (mcount == WINDOW) begin
            chk("model_sum", win_delay_sum, m_sum);
            chk("model_pkt", win_pkt_count, m_pkt);
            chk("model_max", win_max_delay, m_max);
            chk("model_min", win_min_delay, m_min);
            chk("model_ovf", win_ovf, 64'(m_ovf));
            chk("model_udf", win_udf, 64'(m_udf));
            acc_init();
        end
        cyc++;
        mcount = (mcount == WINDOW) ? 0 : mcount + 1;
    endtask

    // Entered and left at posedge+1.
    task automatic tick(input bit s, input bit o);
        start_valid = s;
        over_valid  = o;
        @(negedge clk);
        model_step(s, o);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        over_valid  = 1'b0;
    endtask

    task automatic win_check(input string tag, input win_exp_t e);
        chk({tag, "_sum"}, win_delay_sum, e.sum);
        chk({tag, "_pkt"}, win_pkt_count, e.pkt);
        chk({tag, "_max"}, win_max_delay, e.mx);
        chk({tag, "_min"}, win_min_delay, e.mn);
        chk({tag, "_ovf"}, win_ovf, 64'(e.ovf));
        chk({tag, "_udf"}, win_udf, 64'(e.udf));
    endtask

    task automatic do_reset();
        win_exp_t cleared;
        cleared = '{0, 0, 0, MIN_INIT, 1'b0, 1'b0};
        reset = 1'b0;
        start_valid = 1'b0;
        over_valid = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_win_valid", win_valid, 0);
        win_check("rst_snap", cleared);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_count", count, 0);
        chk("rst_hold_win_valid", win_valid, 0);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t required < 500000", $time);
        $fatal(1);
    end

    initial begin
        vec_t     vecs[5];
        win_exp_t empty_w;
        win_exp_t e;
        int       wnd;
        bit       s, o, closing;

        empty_w = '{0, 0, 0, MIN_INIT, 1'b0, 1'b0};
        vecs[0] = '{11, 0, 41, '{30, 1, 30, 30, 1'b0, 1'b0}, empty_w};  // basic
        vecs[1] = '{95, 1, 5, empty_w, '{10, 1, 10, 10, 1'b0, 1'b0}};   // wrap
        vecs[2] = '{50, 0, 97, '{47, 1, 47, 47, 1'b0, 1'b0}, empty_w};  // commit on close
        vecs[3] = '{50, 0, 98, empty_w, '{48, 1, 48, 48, 1'b0, 1'b0}};  // commit after close
        vecs[4] = '{0, 0, 30, '{0, 0, 0, MIN_INIT, 1'b0, 1'b1}, empty_w}; // underflow

        #1;
        phase = "reset";
        do_reset();

        foreach (vecs[i]) begin
            phase = $sformatf("vec%0d", i);
            do_reset();
            wnd = 0;
            while (wnd < 2) begin
                s = (vecs[i].s_cnt > 0) && (wnd == 0) &&
                    (mcount == vecs[i].s_cnt - 1 || mcount == vecs[i].s_cnt);
                o = (wnd == vecs[i].o_win) &&
                    (mcount == vecs[i].o_cnt - 1 || mcount == vecs[i].o_cnt);
                closing = (mcount == WINDOW);
                tick(s, o);
                if (closing) begin
                    win_check($sformatf("w%0d", wnd), (wnd == 0) ? vecs[i].w0 : vecs[i].w1);
                    wnd++;
                end
            end
        end

        // Five sampled starts (ts 1,5,9,13,17): last one dropped; overs pop 1,5,9,13 in order.
        phase = "overflow";
        do_reset();
        for (int k = 0; k < PERIOD; k++) begin
            if (mcount == 25) chk("level_full", fifo_level, 4);
            tick(mcount <= 19, (mcount >= 30) && (mcount <= 60) && (mcount % 2 == 0));
        end
        e = '{148, 4, 43, 31, 1'b1, 1'b0};
        win_check("w0", e);

        // Reset with three timestamps queued, then an over must underflow.
        phase = "midreset";
        do_reset();
        for (int k = 0; k < 15; k++) tick(mcount <= 9, 1'b0);
        chk("pre_level", fifo_level, 3);
        do_reset();
        for (int k = 0; k < PERIOD; k++) tick(1'b0, mcount == 20 || mcount == 21);
        e = '{0, 0, 0, MIN_INIT, 1'b0, 1'b1};
        win_check("w0", e);

        phase = "random";
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if (k < 1000) tick($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
            else          tick($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
